// File: rtl/riscv_lsu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_lsu_pkg
// Purpose : shared types and constants for the load/store unit.
//   - LDST_* access-size codes (the decoder's mem_size encoding)
//   - lsu_state_e FSM state enum
//   - BE_B/BE_H/BE_W base byte-enable patterns
//   - helpers: size validity, byte-enable and store-lane formation
// Ports   : none (package)
// -----------------------------------------------------------------------------
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  function automatic logic size_valid(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

  // Sub-word accesses ignore the address bits below their own width.
  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] a_lo);
    logic [3:0] be;
    case (size)
      LDST_B, LDST_BU: be = BE_B << a_lo;
      LDST_H, LDST_HU: be = BE_H << {a_lo[1], 1'b0};
      LDST_W:          be = BE_W;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      LDST_B, LDST_BU: w = {4{d[7:0]}};
      LDST_H, LDST_HU: w = {2{d[15:0]}};
      default:         w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_ext_riscv.sv
// -----------------------------------------------------------------------------
// lsu_load_ext_riscv
// Purpose : combinational lane select and sign/zero extension of a load word.
// Ports   :
//   rdata_i   in  32  memory read word
//   size_i    in  3   LDST_* access size
//   addr_lo_i in  2   byte address bits [1:0]
//   data_o    out 32  extended load result (0 for an invalid size)
// -----------------------------------------------------------------------------
module lsu_load_ext_riscv
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: w_byte = rdata_i[7:0];
      2'd1: w_byte = rdata_i[15:8];
      2'd2: w_byte = rdata_i[23:16];
      2'd3: w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
  end

  assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = 32'h0;
    case (size_i)
      LDST_B:  data_o = {{24{w_byte[7]}}, w_byte};
      LDST_BU: data_o = {24'h0, w_byte};
      LDST_H:  data_o = {{16{w_half[15]}}, w_half};
      LDST_HU: data_o = {16'h0, w_half};
      LDST_W:  data_o = rdata_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_riscv.sv
// -----------------------------------------------------------------------------
// lsu_riscv
// Purpose : load/store unit. Takes decoded memory-op fields plus the ALU
//   address, runs one access on a word-addressed data port with byte
//   enables, stalls the core until completion and returns extended load data.
// Optional feature macro: LSU_MISALIGN_EN
//   defined     -> misaligned H/HU/W accesses are refused (no memory request)
//                  and flagged on lsu_misalign_o for one cycle
//   not defined -> lsu_misalign_o is 0, low address bits are truncated
// Ports:
//   clk_i, arstn_i                 clock / async active-low reset
//   lsu_req_i, lsu_we_i            op request, 1=store
//   lsu_size_i [2:0]               LDST_* size
//   lsu_addr_i [31:0]              byte address
//   lsu_data_i [31:0]              store data
//   lsu_data_o [31:0]              extended load data (registered)
//   lsu_stall_req_o                hold pipeline
//   lsu_misalign_o                 misaligned-access flag
//   data_req_o, data_we_o          memory request / write enable
//   data_be_o [3:0]                byte enables
//   data_addr_o [31:0]             word-aligned address
//   data_wdata_o [31:0]            lane-replicated store data
//   data_rdata_i [31:0]            memory read word
//   data_rvalid_i                  access complete
// FSM:
//   state | meaning
//   IDLE  | waiting; stall follows lsu_req_i; latch op on request
//   BUSY  | memory request outstanding until data_rvalid_i
//   DONE  | one cycle, stall released so the core advances
// -----------------------------------------------------------------------------
module lsu_riscv
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  lsu_state_e  r_state;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic [29:0] r_addr_wd;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic        r_misalign;

  logic        w_busy;
  logic        w_misalign;
  logic [31:0] w_ext;

`ifdef LSU_MISALIGN_EN
  assign w_misalign = (((lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU)) && lsu_addr_i[0]) ||
                      ((lsu_size_i == LDST_W) && (lsu_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  lsu_load_ext_riscv u_load_ext (
    .rdata_i   (data_rdata_i),
    .size_i    (r_size),
    .addr_lo_i (r_addr_lo),
    .data_o    (w_ext)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_addr_wd  <= 30'h0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_data     <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_misalign <= 1'b0;
          if (lsu_req_i) begin
            r_we      <= lsu_we_i;
            r_size    <= lsu_size_i;
            r_addr_lo <= lsu_addr_i[1:0];
            r_addr_wd <= lsu_addr_i[31:2];
            r_be      <= lsu_be(lsu_size_i, lsu_addr_i[1:0]);
            r_wdata   <= lsu_wdata(lsu_size_i, lsu_data_i);
            if (!size_valid(lsu_size_i)) begin
              // unknown size: skip memory, present a zero result
              r_data  <= 32'h0;
              r_state <= DONE;
            end else if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (data_rvalid_i) begin
            if (!r_we) r_data <= w_ext;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_misalign <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are decoded from state so an async reset drops them at once.
  assign w_busy       = (r_state == BUSY);
  assign data_req_o   = w_busy;
  assign data_we_o    = w_busy & r_we;
  assign data_be_o    = w_busy ? r_be : 4'h0;
  assign data_addr_o  = w_busy ? {r_addr_wd, 2'b00} : 32'h0;
  assign data_wdata_o = w_busy ? r_wdata : 32'h0;

  assign lsu_data_o     = r_data;
  assign lsu_misalign_o = r_misalign;

  always_comb begin
    lsu_stall_req_o = 1'b0;
    case (r_state)
      IDLE:    lsu_stall_req_o = lsu_req_i;
      BUSY:    lsu_stall_req_o = 1'b1;
      default: lsu_stall_req_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// -----------------------------------------------------------------------------
// tb_lsu_riscv : bench for lsu_riscv. The bench plays both the core (holds the
// request while stalled) and the data memory (answers after a chosen wait).
// Expected outputs come from a transaction-level model of the access rules.
// Honours LSU_MISALIGN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lsu_riscv;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_misalign_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        data_rvalid_i;

  lsu_riscv dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_misalign_o(lsu_misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // per-cycle expectations
  logic        exp_req, exp_stall, exp_mis, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_data;

  // observation counters and last seen bus values
  int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0;
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  // ---------------- model ----------------
  function automatic int nbytes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: return 1;
      SZ_H, SZ_HU: return 2;
      SZ_W:        return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic int lane_off(input logic [2:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    if (n == 1) return int'(addr % 4);
    if (n == 2) return int'((addr % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(size)) - 1) << lane_off(size, addr);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
    case (nbytes(size))
      1:       return {24'h0, d[7:0]} * 32'h0101_0101;
      2:       return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v;
    logic        sgn;
    sgn = (size == SZ_B) || (size == SZ_H);
    v = rd >> (8 * lane_off(size, addr));
    if (nbytes(size) == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nbytes(size) == 2) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic refused(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_EN
    return (nbytes(size) == 2 && addr[0]) || (nbytes(size) == 4 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    chk("data_req", 32'(data_req_o), 32'(exp_req));
    chk("stall", 32'(lsu_stall_req_o), 32'(exp_stall));
    chk("misalign", 32'(lsu_misalign_o), 32'(exp_mis));
    chk("lsu_data", lsu_data_o, exp_data);
    if (exp_req) begin
      chk("data_we", 32'(data_we_o), 32'(exp_we));
      chk("data_be", 32'(data_be_o), 32'(exp_be));
      chk("data_addr", data_addr_o, exp_addr);
      chk("data_wdata", data_wdata_o, exp_wdata);
    end
    if (lsu_stall_req_o) stall_cnt++;
    if (lsu_misalign_o) mis_cnt++;
    if (data_req_o) begin
      req_cnt++;
      last_we = data_we_o; last_be = data_be_o;
      last_addr = data_addr_o; last_wdata = data_wdata_o;
    end
  endtask

  // inputs/expectations are set at posedge+1, compared at negedge
  task automatic end_cycle();
    @(negedge clk_i);
    cmp_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int wt,
                       input int gap);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_data_i = wd;
    data_rvalid_i = 1'($urandom % 2);
    data_rdata_i = $urandom;
    exp_req = 1'b0; exp_stall = 1'b1; exp_mis = 1'b0;
    end_cycle();
    if (nbytes(size) == 0 || refused(size, addr)) begin
      data_rvalid_i = 1'($urandom % 2);
      exp_stall = 1'b0;
      exp_mis = (nbytes(size) != 0);
      if (nbytes(size) == 0) exp_data = 32'h0;
      end_cycle();
    end else begin
      exp_we = we; exp_be = m_be(size, addr);
      exp_addr = addr & 32'hFFFF_FFFC; exp_wdata = m_wdata(size, wd);
      for (int k = 0; k <= wt; k++) begin
        // scramble the core-side inputs: the unit must use its latched copy
        lsu_addr_i = $urandom; lsu_data_i = $urandom; lsu_size_i = 3'($urandom);
        data_rvalid_i = (k == wt);
        data_rdata_i = (k == wt) ? rd : $urandom;
        exp_req = 1'b1; exp_stall = 1'b1;
        end_cycle();
      end
      data_rvalid_i = 1'($urandom % 2);
      data_rdata_i = $urandom;
      exp_req = 1'b0; exp_stall = 1'b0;
      if (!we) exp_data = m_load(size, addr, rd);
      end_cycle();
    end
    for (int g = 0; g < gap; g++) begin
      lsu_req_i = 1'b0;
      data_rvalid_i = 1'($urandom % 2);
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
      end_cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  int s_st, s_rq, s_ms;
  logic [2:0]  r_size;
  logic [2:0]  valid_sizes [5];

  initial begin
    valid_sizes[0] = SZ_B; valid_sizes[1] = SZ_H; valid_sizes[2] = SZ_W;
    valid_sizes[3] = SZ_BU; valid_sizes[4] = SZ_HU;
    arstn_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'b000;
    lsu_addr_i = 32'h0; lsu_data_i = 32'h0; data_rdata_i = 32'h0; data_rvalid_i = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
    exp_be = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_data = 32'h0;
    last_we = 1'b0; last_be = 4'h0; last_addr = 32'h0; last_wdata = 32'h0;

    @(posedge clk_i); #1;
    chk("rst data_req", 32'(data_req_o), 32'h0);
    chk("rst data_we", 32'(data_we_o), 32'h0);
    chk("rst data_be", 32'(data_be_o), 32'h0);
    chk("rst data_addr", data_addr_o, 32'h0);
    chk("rst data_wdata", data_wdata_o, 32'h0);
    chk("rst stall", 32'(lsu_stall_req_o), 32'h0);
    chk("rst misalign", 32'(lsu_misalign_o), 32'h0);
    chk("rst lsu_data", lsu_data_o, 32'h0);
    arstn_i = 1'b1;
    end_cycle();

    // 1: LB 0x103, answer in first BUSY cycle
    s_st = stall_cnt;
    do_op(1'b0, SZ_B, 32'h103, 32'h0, 32'h80AA_BBCC, 0, 1);
    chk("t1 stall cycles", 32'(stall_cnt - s_st), 32'd2);
    chk("t1 be", 32'(last_be), 32'h8);
    chk("t1 addr", last_addr, 32'h100);
    chk("t1 data", lsu_data_o, 32'hFFFF_FF80);

    // 2: LHU / LH 0x202
    do_op(1'b0, SZ_HU, 32'h202, 32'h0, 32'hBEEF_1234, 1, 1);
    chk("t2 be", 32'(last_be), 32'hC);
    chk("t2 lhu data", lsu_data_o, 32'h0000_BEEF);
    do_op(1'b0, SZ_H, 32'h202, 32'h0, 32'hBEEF_1234, 0, 1);
    chk("t2 lh data", lsu_data_o, 32'hFFFF_BEEF);

    // 3: SB 0x301
    do_op(1'b1, SZ_B, 32'h301, 32'h1234_56A5, 32'hDEAD_BEEF, 0, 1);
    chk("t3 we", 32'(last_we), 32'h1);
    chk("t3 be", 32'(last_be), 32'h2);
    chk("t3 wdata", last_wdata, 32'hA5A5_A5A5);
    chk("t3 data held", lsu_data_o, 32'hFFFF_BEEF);

    // 4: SW with 3 wait cycles
    s_st = stall_cnt; s_rq = req_cnt;
    do_op(1'b1, SZ_W, 32'h400, 32'hCAFE_F00D, 32'h0, 3, 1);
    chk("t4 req cycles", 32'(req_cnt - s_rq), 32'd4);
    chk("t4 stall cycles", 32'(stall_cnt - s_st), 32'd5);

    // 5: reset during BUSY, stray rvalid afterwards
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = SZ_W; lsu_addr_i = 32'h500;
    data_rvalid_i = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b1; exp_mis = 1'b0;
    end_cycle();
    exp_req = 1'b1; exp_stall = 1'b1; exp_we = 1'b0; exp_be = 4'hF;
    exp_addr = 32'h500; exp_wdata = lsu_data_i;
    end_cycle();
    #2;
    arstn_i = 1'b0; lsu_req_i = 1'b0;
    #1;
    chk("t5 req dropped", 32'(data_req_o), 32'h0);
    chk("t5 stall dropped", 32'(lsu_stall_req_o), 32'h0);
    chk("t5 be dropped", 32'(data_be_o), 32'h0);
    chk("t5 data cleared", lsu_data_o, 32'h0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1357_9BDF;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_data = 32'h0;
    end_cycle();
    data_rvalid_i = 1'b0;
    end_cycle();
    chk("t5 late rvalid ignored", lsu_data_o, 32'h0);

    // 6: LW 0x102
    do_op(1'b0, SZ_W, 32'h0, 32'h0, 32'h2468_ACE0, 0, 1);
    s_st = stall_cnt; s_rq = req_cnt; s_ms = mis_cnt;
    do_op(1'b0, SZ_W, 32'h102, 32'h0, 32'h1111_2222, 0, 1);
`ifdef LSU_MISALIGN_EN
    chk("t6 no request", 32'(req_cnt - s_rq), 32'd0);
    chk("t6 misalign cycles", 32'(mis_cnt - s_ms), 32'd1);
    chk("t6 stall cycles", 32'(stall_cnt - s_st), 32'd1);
    chk("t6 data held", lsu_data_o, 32'h2468_ACE0);
`else
    chk("t6 be", 32'(last_be), 32'hF);
    chk("t6 addr", last_addr, 32'h100);
    chk("t6 misalign cycles", 32'(mis_cnt - s_ms), 32'd0);
    chk("t6 data", lsu_data_o, 32'h1111_2222);
`endif

    // invalid size: no access, zero result, one stall cycle
    s_st = stall_cnt; s_rq = req_cnt;
    do_op(1'b0, 3'b110, 32'h600, 32'h0, 32'hFFFF_FFFF, 0, 1);
    chk("inv stall cycles", 32'(stall_cnt - s_st), 32'd1);
    chk("inv no request", 32'(req_cnt - s_rq), 32'd0);
    chk("inv data", lsu_data_o, 32'h0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) r_size = 3'b011 | 3'($urandom_range(0, 1) << 2);
      else r_size = valid_sizes[$urandom_range(0, 4)];
      do_op(1'($urandom % 2), r_size, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
